// File: rtl/fixed_point_multiplier.sv
// Sequential signed fixed-point multiplier, p = (x*y) >> floating_bits, one bit per clock.
// Define MULT_SATURATE_EN to clamp p on overflow instead of returning 0.
module fixed_point_multiplier #(
  parameter int width         = 32,
  parameter int floating_bits = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             ovf,
  input  logic [width-1:0] x,
  input  logic [width-1:0] y,
  output logic [width-1:0] p
);

  localparam int AW = 2 * width;
  localparam int CW = $clog2(width) + 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  localparam logic [AW-1:0] LIM_P =
    {{(width + 1){1'b0}}, {(width - 1){1'b1}}};
  localparam logic [AW-1:0] LIM_N =
    {{width{1'b0}}, 1'b1, {(width - 1){1'b0}}};

`ifdef MULT_SATURATE_EN
  localparam logic [width-1:0] SAT_P = {1'b0, {(width - 1){1'b1}}};
  localparam logic [width-1:0] SAT_N = {1'b1, {(width - 1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM
  } state_t;

  state_t state, state_n;

  logic             sign;
  logic             zpend;
  logic             nphase;
  logic             ovf_r;
  logic [AW-1:0]    mx;
  logic [width-1:0] my;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [width-1:0] res_r;

  logic             accept;
  logic             op_zero;
  logic [width-1:0] ax;
  logic [width-1:0] ay;
  logic [AW-1:0]    mag;
  logic [width-1:0] p_sat;

  assign ax      = x[width-1] ? -x : x;
  assign ay      = y[width-1] ? -y : y;
  assign op_zero = (x == '0) || (y == '0);
  assign mag     = acc >> floating_bits;
  assign busy    = (state != IDLE);

`ifdef MULT_SATURATE_EN
  assign p_sat = sign ? SAT_N : SAT_P;
`else
  assign p_sat = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !valid && !zpend) begin
          accept = 1'b1;
          if (!op_zero) state_n = MUL;
        end
      end
      MUL:     if (cnt == LAST) state_n = NORM;
      NORM:    if (nphase) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign   <= 1'b0;
      zpend  <= 1'b0;
      nphase <= 1'b0;
      ovf_r  <= 1'b0;
      mx     <= '0;
      my     <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_r  <= '0;
      valid  <= 1'b0;
      ovf    <= 1'b0;
      p      <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (zpend) begin
            zpend <= 1'b0;
            valid <= 1'b1;
            ovf   <= 1'b0;
            p     <= '0;
          end else if (accept) begin
            sign   <= x[width-1] ^ y[width-1];
            mx     <= {{width{1'b0}}, ax};
            my     <= ay;
            acc    <= '0;
            cnt    <= '0;
            nphase <= 1'b0;
            ovf    <= 1'b0;
            zpend  <= op_zero;
          end
        end
        MUL: begin
          if (my[0]) acc <= acc + mx;
          mx  <= mx << 1;
          my  <= my >> 1;
          cnt <= cnt + CW'(1);
        end
        NORM: begin
          // First cycle registers the range check, second forms p.
          if (!nphase) begin
            nphase <= 1'b1;
            res_r  <= mag[width-1:0];
            ovf_r  <= sign ? (mag > LIM_N) : (mag > LIM_P);
          end else begin
            nphase <= 1'b0;
            valid  <= 1'b1;
            ovf    <= ovf_r;
            if (ovf_r)     p <= p_sat;
            else if (sign) p <= -res_r;
            else           p <= res_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Directed vector bench for fixed_point_multiplier (width=32, floating_bits=16).
// Covers latency, busy profile, zero shortcut, overflow limits and mid-op disturbance.
module tb_fixed_point_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        valid;
  logic        ovf;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] p;

  int checks;
  int errors;

`ifdef MULT_SATURATE_EN
  localparam logic [31:0] SP = 32'h7FFF_FFFF;
  localparam logic [31:0] SN = 32'h8000_0000;
`else
  localparam logic [31:0] SP = 32'h0;
  localparam logic [31:0] SN = 32'h0;
`endif

  fixed_point_multiplier #(
    .width(32),
    .floating_bits(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .busy(busy),
    .valid(valid),
    .ovf(ovf),
    .x(x),
    .y(y),
    .p(p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] vx;
    logic [31:0] vy;
    logic [31:0] ep;
    logic        eovf;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request; return latency (edges after accept until valid)
  // and whether busy ever deviated from the expected profile.
  task automatic run_op(input logic [31:0] vx, input logic [31:0] vy,
                        input bit exp_busy, output int lat,
                        output bit busy_bad);
    @(negedge clk);
    start = 1'b1;
    x     = vx;
    y     = vy;
    @(posedge clk);
    #1;
    start    = 1'b0;
    x        = 32'hDEAD_BEEF;
    y        = 32'h1357_9BDF;
    busy_bad = (busy !== exp_busy);
    lat      = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid) break;
      if (busy !== exp_busy) busy_bad = 1'b1;
    end
  endtask

  vec_t vecs[$];
  int   lat;
  bit   bb;
  bit   seen;

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    x      = '0;
    y      = '0;
    rst_n  = 1'b0;

    vecs.push_back('{"p15x2",   32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, 34});
    vecs.push_back('{"m15x2",   32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, 34});
    vecs.push_back('{"m15xm2",  32'hFFFE_8000, 32'hFFFE_0000, 32'h0003_0000, 1'b0, 34});
    vecs.push_back('{"minx1",   32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 34});
    vecs.push_back('{"zero_x",  32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{"zero_y",  32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{"half_sq", 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0, 34});
    vecs.push_back('{"3p25xm4", 32'h0003_4000, 32'hFFFC_0000, 32'hFFF3_0000, 1'b0, 34});
    vecs.push_back('{"trunc_p", 32'h0001_8000, 32'h0000_0001, 32'h0000_0001, 1'b0, 34});
    vecs.push_back('{"trunc_n", 32'hFFFE_8000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 34});
    vecs.push_back('{"tiny",    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 34});
    vecs.push_back('{"neg0",    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 34});
    vecs.push_back('{"negmin",  32'hFF00_0000, 32'h0080_0000, 32'h8000_0000, 1'b0, 34});
    vecs.push_back('{"ovf_pos", 32'h0100_0000, 32'h0100_0000, SP,            1'b1, 34});
    vecs.push_back('{"ovf_lim", 32'h0080_0000, 32'h0100_0000, SP,            1'b1, 34});
    vecs.push_back('{"ovf_neg", 32'hFF00_0000, 32'h0100_0000, SN,            1'b1, 34});

    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_p", 64'(p), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].vx, vecs[i].vy, vecs[i].lat != 1, lat, bb);
      chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
      chk({vecs[i].name, "_busy"}, 64'(bb), 64'(0));
      chk({vecs[i].name, "_p"}, 64'(p), 64'(vecs[i].ep));
      chk({vecs[i].name, "_ovf"}, 64'(ovf), 64'(vecs[i].eovf));
      chk({vecs[i].name, "_busy_v"}, 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_pulse"}, 64'(valid), 64'(0));
    end

    // start during the valid cycle must be ignored
    run_op(32'h0001_8000, 32'h0002_0000, 1'b1, lat, bb);
    @(negedge clk);
    start = 1'b1;
    x     = 32'h0100_0000;
    y     = 32'h0100_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy || valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("vcyc_ignored", 64'(seen), 64'(0));
    chk("vcyc_p", 64'(p), 64'h3_0000);

    // start at T+5 while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    x     = 32'h0001_8000;
    y     = 32'h0002_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x     = 32'h0100_0000;
    y     = 32'h0100_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 5;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid) break;
    end
    chk("busy_start_lat", 64'(lat), 64'(34));
    chk("busy_start_p", 64'(p), 64'h3_0000);
    chk("busy_start_ovf", 64'(ovf), 64'(0));

    // reset at T+10 aborts the operation
    @(negedge clk);
    start = 1'b1;
    x     = 32'hFFFE_8000;
    y     = 32'h0002_0000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(valid), 64'(0));
    chk("abort_p", 64'(p), 64'(0));
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'(0));
    run_op(32'h0003_4000, 32'hFFFC_0000, 1'b1, lat, bb);
    chk("post_abort_lat", 64'(lat), 64'(34));
    chk("post_abort_p", 64'(p), 64'hFFF3_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
